// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  is_read;
  } arb_tag_t;

  function automatic arb_tag_t make_tag(input logic f_gnt, input logic d_gnt, input logic d_we);
    arb_tag_t t;
    t.valid   = f_gnt | d_gnt;
    t.port    = d_gnt ? PORT_D : PORT_F;
    t.is_read = f_gnt | (d_gnt & ~d_we);
    return t;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and RAM-side signal bundle for mem_arbiter.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection. MEM_ARB_RR_EN selects round-robin on
// contention; otherwise data has fixed priority over fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic  f_req,
  input  logic  d_req,
  input  port_e last,
  output logic  f_gnt,
  output logic  d_gnt
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    f_gnt = f_req;
    d_gnt = d_req;
    if (f_req && d_req) begin
      f_gnt = (last == PORT_D);
      d_gnt = (last == PORT_F);
    end
  end
`else
  logic last_unused;
  assign last_unused = last;

  always_comb begin
    d_gnt = d_req;
    f_gnt = f_req & ~d_req;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM between fetch and load/store paths; reads return
// two cycles after grant. MEM_ARB_RR_EN enables round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
)(
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  bus
);

  logic          f_pick, d_pick;
  logic          f_gnt_c, d_gnt_c;
  port_e         last_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_wdata_q;
  arb_tag_t      tag1_q, tag2_q;

  mem_arb_pick u_pick (
    .f_req (bus.f_req),
    .d_req (bus.d_req),
    .last  (last_q),
    .f_gnt (f_pick),
    .d_gnt (d_pick)
  );

  assign f_gnt_c = f_pick & ~rst;
  assign d_gnt_c = d_pick & ~rst;

`ifdef MEM_ARB_RR_EN
  // Reset to data so that fetch wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PORT_D;
    end else if (f_gnt_c) begin
      last_q <= PORT_F;
    end else if (d_gnt_c) begin
      last_q <= PORT_D;
    end
  end
`else
  assign last_q = PORT_D;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
    end else begin
      mem_we_q <= d_gnt_c & bus.d_we;
      if (d_gnt_c) begin
        mem_addr_q <= bus.d_addr;
        if (bus.d_we) begin
          mem_wdata_q <= bus.d_wdata;
        end
      end else if (f_gnt_c) begin
        mem_addr_q <= bus.f_addr;
      end
      tag1_q <= make_tag(f_gnt_c, d_gnt_c, bus.d_we);
      tag2_q <= tag1_q;
    end
  end

  assign bus.f_gnt     = f_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Stage 2 is still live during the reset cycle, so rst masks it directly.
  assign bus.f_rvalid = tag2_q.valid & tag2_q.is_read & (tag2_q.port == PORT_F) & ~rst;
  assign bus.d_rvalid = tag2_q.valid & tag2_q.is_read & (tag2_q.port == PORT_D) & ~rst;
  assign bus.f_rdata  = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;

endmodule
